match_sched: RTL and testbench
==============================

MATCH_SCHED -- requirements
Module: match_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one matcher engine.
REQ-002 SHALL have parameter WORD_LENGTH, default 3, bytes per query word.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, bits per byte.
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum engine cycles per job.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester request level, held until granted.
REQ-008 SHALL have port req_word  input  NUM_REQ*WORD_LENGTH*DATA_WIDTH  query word per requester; slice i belongs to requester i.
REQ-009 SHALL have port gnt  output  NUM_REQ  one-hot single-cycle grant pulse.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port rsp_id  output  $clog2(NUM_REQ)  index of requester owning the result.
REQ-013 SHALL have port rsp_found  output  1  word present in vocabulary.
REQ-014 SHALL have port rsp_timeout  output  1  job aborted by timeout.
REQ-015 SHALL have port m_clr_n  output  1  active-low restart to matcher engine.
REQ-016 SHALL have port m_cs  output  1  matcher start strobe.
REQ-017 SHALL have port m_word  output  WORD_LENGTH*DATA_WIDTH  registered query word to matcher.
REQ-018 SHALL have ports m_done, m_found  input  1 each  matcher completion and result.

Function
REQ-019 SHALL implement states IDLE, CLEAR, LAUNCH, BUSY, RESP.
REQ-020 IDLE: if any req bit set, SHALL select winner by round-robin starting at pointer rr_ptr, capture its word into m_word, pulse gnt[winner] for that cycle, go to CLEAR.
REQ-021 CLEAR: SHALL drive m_clr_n=0 for exactly one cycle, then LAUNCH.
REQ-022 LAUNCH: SHALL drive m_cs=1 for exactly one cycle, clear timeout counter, then BUSY.
REQ-023 BUSY: SHALL increment timeout counter each cycle; on m_done=1 SHALL latch rsp_found=m_found, rsp_timeout=0, go RESP.
REQ-024 BUSY: if counter reaches TIMEOUT-1 with m_done=0, SHALL latch rsp_found=0, rsp_timeout=1, go RESP.
REQ-025 m_done and timeout in same cycle: m_done SHALL win.
REQ-026 RESP: SHALL hold rsp_valid=1 and stable rsp_id/rsp_found/rsp_timeout until rsp_ready=1; on acceptance SHALL go IDLE and set rr_ptr=(winner+1) mod NUM_REQ.
REQ-027 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-028 Requester deasserting req before grant SHALL simply lose eligibility; no error.
REQ-029 Request-to-m_cs latency SHALL be 2 cycles (grant cycle, CLEAR); minimum request-to-rsp_valid = 3 + engine latency.
REQ-030 gnt SHALL be zero outside IDLE-with-grant cycle; m_clr_n SHALL be 1 outside CLEAR; m_cs SHALL be 0 outside LAUNCH.
REQ-031 rr_ptr SHALL wrap from NUM_REQ-1 to 0; a single persistent requester SHALL be re-granted every job.

Reset
REQ-032 On rst_n=0 SHALL asynchronously enter IDLE with gnt=0, rsp_valid=0, rsp_id=0, rsp_found=0, rsp_timeout=0, m_cs=0, m_clr_n=0, m_word=0, rr_ptr=0, counter=0.
REQ-033 m_clr_n SHALL return to 1 on the first clock after reset release.
REQ-034 Reset mid-job SHALL abandon the job without emitting a response.

Structure
REQ-035 State enum and default parameter constants SHALL live in shared package match_pkg.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter (req, ptr in; one-hot grant and index out, combinational).
REQ-037 Timeout counter width SHALL be $clog2(TIMEOUT)+1.

Verification
REQ-038 req=4'b0001, word 0x414243, engine done+found after 5 cycles -> gnt=0001, one CLEAR, one m_cs, rsp_valid with id=0, found=1, timeout=0.
REQ-039 req=4'b1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0.
REQ-040 m_done never asserted, TIMEOUT=64 -> rsp_valid 64 cycles after LAUNCH, found=0, timeout=1.
REQ-041 rsp_ready=0 for 10 cycles in RESP -> outputs stable, no new gnt despite req=4'b0110.
REQ-042 m_done on same cycle counter hits TIMEOUT-1, m_found=1 -> found=1, timeout=0.
REQ-043 rst_n pulsed during BUSY -> all outputs reset values, no rsp_valid, next grant starts at requester 0.

Source files
------------

// File: rtl/match_pkg.sv
// match_pkg: shared definitions for the match scheduler slice.
// Holds the scheduler state encoding and the default parameter values
// used by match_sched. No ports; imported by the top module.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LAUNCH,
    BUSY,
    RESP
  } state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_WORD_LENGTH = 3;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_TIMEOUT     = 64;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - requester index that has highest priority this round
//   grant     - one-hot grant of the selected requester (zero if no request)
//   grant_idx - binary index of the selected requester (zero if no request)
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NUM_REQ);
  // One extra bit so ptr + offset never overflows before the wrap.
  localparam int SW = IW + 1;

  logic [SW-1:0] pos;
  logic          hit;

  // Scan requesters starting at ptr and wrapping around; the first
  // active one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    hit       = 1'b0;
    pos       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(NUM_REQ)) begin
        pos = pos - SW'(NUM_REQ);
      end
      if (!hit && req[pos[IW-1:0]]) begin
        hit                = 1'b1;
        grant[pos[IW-1:0]] = 1'b1;
        grant_idx          = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/match_sched.sv
// match_sched: shares one matcher engine between NUM_REQ requesters.
// A round-robin winner's query word is handed to the engine, the engine
// is restarted (m_clr_n) and launched (m_cs), and the result or a
// timeout is presented on the rsp_* handshake until accepted.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   req, req_word        - request levels and per-requester query words
//   gnt                  - one-hot grant pulse in the arbitration cycle
//   rsp_valid/rsp_ready  - result handshake; rsp_id/rsp_found/rsp_timeout
//   m_clr_n, m_cs, m_word - restart, start strobe and query word to engine
//   m_done, m_found      - engine completion and match result
module match_sched
  import match_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_REQ-1:0]                        req,
  input  logic [NUM_REQ*WORD_LENGTH*DATA_WIDTH-1:0] req_word,
  output logic [NUM_REQ-1:0]                        gnt,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]                rsp_id,
  output logic                                      rsp_found,
  output logic                                      rsp_timeout,
  output logic                                      m_clr_n,
  output logic                                      m_cs,
  output logic [WORD_LENGTH*DATA_WIDTH-1:0]         m_word,
  input  logic                                      m_done,
  input  logic                                      m_found
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = WORD_LENGTH * DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_LAST = IW'(NUM_REQ - 1);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_inc;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic [WW-1:0]      sel_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (arb_gnt),
    .grant_idx (arb_idx)
  );

  assign sel_word = req_word[int'(arb_idx)*WW +: WW];
  assign tmo_inc  = tmo_cnt + CW'(1);

  // The grant is shown in the same cycle the word is captured, so a
  // requester can drop its request on the following edge. Held low while
  // in reset so a waiting requester never sees a spurious grant.
  assign gnt = (state == IDLE && rst_n) ? arb_gnt : '0;

  // Job sequencer. tmo_inc is compared rather than tmo_cnt so that the
  // TIMEOUT budget counts the LAUNCH cycle as the first engine cycle.
  // In BUSY, m_done is tested first so a completion on the last allowed
  // cycle is reported as a real result rather than a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_found   <= 1'b0;
      rsp_timeout <= 1'b0;
      m_clr_n     <= 1'b0;
      m_cs        <= 1'b0;
      m_word      <= '0;
    end else begin
      case (state)
        IDLE: begin
          m_clr_n <= 1'b1;
          m_cs    <= 1'b0;
          if (|req) begin
            m_word  <= sel_word;
            rsp_id  <= arb_idx;
            m_clr_n <= 1'b0;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          m_clr_n <= 1'b1;
          m_cs    <= 1'b1;
          state   <= LAUNCH;
        end
        LAUNCH: begin
          m_cs    <= 1'b0;
          tmo_cnt <= '0;
          state   <= BUSY;
        end
        BUSY: begin
          tmo_cnt <= tmo_inc;
          if (m_done) begin
            rsp_found   <= m_found;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (tmo_inc == CNT_LAST) begin
            rsp_found   <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (rsp_id == PTR_LAST) ? '0 : rsp_id + IW'(1);
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_sched.sv
// tb_match_sched: self-checking bench for match_sched.
// Runs a table of directed jobs, a reset-during-job sequence, and a batch
// of random jobs judged by a transaction-level model of the scheduler.
module tb_match_sched;

  localparam int NR = 4;
  localparam int WL = 3;
  localparam int DW = 8;
  localparam int TO = 64;
  localparam int WW = WL * DW;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*WW-1:0] req_word;
  logic [NR-1:0]    gnt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic             rsp_found;
  logic             rsp_timeout;
  logic             m_clr_n;
  logic             m_cs;
  logic [WW-1:0]    m_word;
  logic             m_done;
  logic             m_found;

  int   errors  = 0;
  int   checks  = 0;
  int   job_no  = 0;
  int   eng_lat = -1;
  logic eng_found = 1'b0;
  int   eng_rem;
  logic cs_prev;
  logic clr_prev;
  int   mdl_ptr;

  typedef struct {
    logic [3:0]  req;
    logic [95:0] words;
    int          lat;
    logic        fnd;
    int          delay;
    logic [3:0]  hold;
    logic [3:0]  e_gnt;
    int          e_id;
    logic        e_found;
    logic        e_to;
    int          e_cyc;
  } vec_t;

  vec_t vecs [10];

  logic [3:0]  r_req;
  int          r_lat;
  logic        r_fnd;
  int          r_delay;
  logic [95:0] r_words;
  int          r_win;
  logic        r_ef;
  logic        r_et;
  int          r_cyc;

  match_sched #(
    .NUM_REQ     (NR),
    .WORD_LENGTH (WL),
    .DATA_WIDTH  (DW),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_word    (req_word),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_found   (rsp_found),
    .rsp_timeout (rsp_timeout),
    .m_clr_n     (m_clr_n),
    .m_cs        (m_cs),
    .m_word      (m_word),
    .m_done      (m_done),
    .m_found     (m_found)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Behavioural matcher engine: after a start strobe it answers with a
  // one-cycle m_done eng_lat cycles later (eng_lat <= 0 means never).
  // A restart pulse or reset cancels any pending answer.
  initial begin
    m_done   = 1'b0;
    m_found  = 1'b0;
    eng_rem  = -1;
    forever begin
      @(negedge clk);
      cs_prev  = m_cs;
      clr_prev = m_clr_n;
      @(posedge clk);
      #1;
      m_done = 1'b0;
      if (!rst_n || !clr_prev) eng_rem = -1;
      else if (cs_prev) eng_rem = (eng_lat > 0) ? eng_lat - 1 : -1;
      else if (eng_rem >= 0) eng_rem = eng_rem - 1;
      if (eng_rem == 0) begin
        m_done  = 1'b1;
        m_found = eng_found;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL job%0d %s: actual=%0h required=%0h", job_no, name, act, exp);
    end
  endtask

  function automatic int rrPick(input logic [3:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  // One complete job: present requests, check grant, engine handshake,
  // response timing/content, stability while stalled, then accept.
  // Called just after a rising edge; returns just after a rising edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [95:0] words, input int lat,
                               input logic fnd, input int delay, input logic [3:0] hold,
                               input logic [3:0] e_gnt, input int e_id, input logic e_found,
                               input logic e_to, input int e_cyc);
    int          n;
    int          cyc;
    int          clr_cnt;
    int          cs_cnt;
    int          clr_at;
    int          cs_at;
    int          gnt_extra;
    logic        got;
    logic [95:0] tmp;
    logic [WW-1:0] exp_word;

    req       = r;
    req_word  = words;
    eng_lat   = lat;
    eng_found = fnd;
    rsp_ready = 1'b0;
    tmp       = words >> (WW * e_id);
    exp_word  = tmp[WW-1:0];

    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (n == 0) checkOutput("rsp_idle", 32'(rsp_valid), 32'(0));
      if (gnt != '0) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    checkOutput("gnt", 32'(gnt), 32'(e_gnt));
    if (!got) return;

    cyc = 0; clr_cnt = 0; cs_cnt = 0; clr_at = -1; cs_at = -1; gnt_extra = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      @(negedge clk);
      if (!m_clr_n) begin clr_cnt++; clr_at = cyc; end
      if (m_cs) begin cs_cnt++; cs_at = cyc; end
      if (gnt != '0) gnt_extra++;
      if (cyc == 1) checkOutput("m_word", 32'(m_word), 32'(exp_word));
      if (rsp_valid) got = 1'b1;
    end
    checkOutput("latency", cyc, e_cyc);
    checkOutput("clr_pulses", clr_cnt, 1);
    checkOutput("clr_cycle", clr_at, 1);
    checkOutput("cs_pulses", cs_cnt, 1);
    checkOutput("cs_cycle", cs_at, 2);
    checkOutput("gnt_quiet", gnt_extra, 0);
    checkOutput("rsp_id", 32'(rsp_id), e_id);
    checkOutput("rsp_found", 32'(rsp_found), 32'(e_found));
    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
    if (!got) return;

    if (hold != 4'b0000) req = hold;
    for (int d = 0; d < delay; d++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("hold_valid", 32'(rsp_valid), 32'(1));
      checkOutput("hold_id", 32'(rsp_id), e_id);
      checkOutput("hold_found", 32'(rsp_found), 32'(e_found));
      checkOutput("hold_timeout", 32'(rsp_timeout), 32'(e_to));
      checkOutput("hold_gnt", 32'(gnt), 32'(0));
    end

    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    // Directed jobs starting from the reset pointer (requester 0).
    vecs[0] = '{4'b0001, 96'h000000_000000_000000_414243, 5,  1'b1, 0,  4'b0000, 4'b0001, 0, 1'b1, 1'b0, 8};
    vecs[1] = '{4'b1111, 96'h3A3B3C_2A2B2C_1A1B1C_0A0B0C, 2,  1'b0, 0,  4'b0000, 4'b0010, 1, 1'b0, 1'b0, 5};
    vecs[2] = '{4'b1111, 96'h3D3E3F_2D2E2F_1D1E1F_0D0E0F, 3,  1'b1, 2,  4'b0000, 4'b0100, 2, 1'b1, 1'b0, 6};
    vecs[3] = '{4'b1111, 96'h313233_212223_111213_010203, 1,  1'b1, 0,  4'b0000, 4'b1000, 3, 1'b1, 1'b0, 4};
    vecs[4] = '{4'b1111, 96'hA1A2A3_B1B2B3_C1C2C3_D1D2D3, 4,  1'b0, 0,  4'b0000, 4'b0001, 0, 1'b0, 1'b0, 7};
    vecs[5] = '{4'b0001, 96'h000000_000000_000000_C0FFEE, 7,  1'b1, 0,  4'b0000, 4'b0001, 0, 1'b1, 1'b0, 10};
    vecs[6] = '{4'b1000, 96'hABCDEF_000000_000000_000000, 63, 1'b1, 0,  4'b0000, 4'b1000, 3, 1'b1, 1'b0, 66};
    vecs[7] = '{4'b0100, 96'h000000_123456_000000_000000, 64, 1'b1, 0,  4'b0000, 4'b0100, 2, 1'b0, 1'b1, 66};
    vecs[8] = '{4'b1001, 96'h777777_666666_555555_444444, 0,  1'b1, 10, 4'b0110, 4'b1000, 3, 1'b0, 1'b1, 66};
    vecs[9] = '{4'b0110, 96'h010101_FEDCBA_987654_020202, 6,  1'b1, 1,  4'b0000, 4'b0010, 1, 1'b1, 1'b0, 9};

    rst_n     = 1'b0;
    req       = '0;
    req_word  = '0;
    rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gnt", 32'(gnt), 32'(0));
    checkOutput("reset_valid", 32'(rsp_valid), 32'(0));
    checkOutput("reset_clr_n", 32'(m_clr_n), 32'(0));
    checkOutput("reset_cs", 32'(m_cs), 32'(0));
    checkOutput("reset_word", 32'(m_word), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("release_clr_n", 32'(m_clr_n), 32'(1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      job_no = i;
      applyStimulus(vecs[i].req, vecs[i].words, vecs[i].lat, vecs[i].fnd, vecs[i].delay,
                    vecs[i].hold, vecs[i].e_gnt, vecs[i].e_id, vecs[i].e_found,
                    vecs[i].e_to, vecs[i].e_cyc);
    end

    // Reset while the engine is busy on requester 2's job.
    job_no    = 100;
    req       = 4'b0100;
    req_word  = 96'h111111_222222_333333_444444;
    eng_lat   = -1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (gnt == '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("rst_job_gnt", 32'(gnt), 32'(4'b0100));
    end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_gnt", 32'(gnt), 32'(0));
    checkOutput("midrst_valid", 32'(rsp_valid), 32'(0));
    checkOutput("midrst_id", 32'(rsp_id), 32'(0));
    checkOutput("midrst_found", 32'(rsp_found), 32'(0));
    checkOutput("midrst_timeout", 32'(rsp_timeout), 32'(0));
    checkOutput("midrst_cs", 32'(m_cs), 32'(0));
    checkOutput("midrst_clr_n", 32'(m_clr_n), 32'(0));
    checkOutput("midrst_word", 32'(m_word), 32'(0));
    req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("postrst_clr_n", 32'(m_clr_n), 32'(1));
      checkOutput("postrst_valid", 32'(rsp_valid), 32'(0));
    end
    @(posedge clk);
    #1;
    job_no = 101;
    applyStimulus(4'b1111, 96'h0F0F0F_0E0E0E_0D0D0D_0C0C0C, 3, 1'b1, 0, 4'b0000,
                  4'b0001, 0, 1'b1, 1'b0, 6);

    // Random jobs against a transaction-level model: winner is the first
    // requesting index at or after the pointer, the engine answer counts
    // only if it arrives within TO-1 cycles of the launch.
    mdl_ptr = (0 + 1) % NR;
    for (int j = 0; j < 40; j++) begin
      job_no  = 200 + j;
      r_req   = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) r_lat = int'($urandom_range(0, 70));
      else r_lat = int'($urandom_range(1, 12));
      r_fnd   = 1'($urandom_range(0, 1));
      r_delay = int'($urandom_range(0, 3));
      r_words = {$urandom, $urandom, $urandom};
      r_win   = rrPick(r_req, mdl_ptr);
      if (r_lat >= 1 && r_lat <= TO - 1) begin
        r_ef  = r_fnd;
        r_et  = 1'b0;
        r_cyc = 3 + r_lat;
      end else begin
        r_ef  = 1'b0;
        r_et  = 1'b1;
        r_cyc = 2 + TO;
      end
      applyStimulus(r_req, r_words, r_lat, r_fnd, r_delay, 4'b0000,
                    4'(1 << r_win), r_win, r_ef, r_et, r_cyc);
      mdl_ptr = (r_win + 1) % NR;
    end

    req = '0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
